// File: rtl/exu_dp_arbiter.sv
// exu_dp_arbiter -- sequencing arbiter for the shared execute-stage ALU datapath.
//
// Four requesters (ALU, BJP, MEM, CSR) compete for one datapath. A winner is
// granted for a single EXEC cycle, in which the one-hot dp_req_* line and the
// matching *_ready_o are high. The datapath result and compare flag are
// captured at the end of EXEC and held in HOLD under a valid/ready handshake
// towards writeback.
//
// Optional feature (macro EXU_DP_ARB_RR_EN):
//   defined   : round-robin arbitration with a 2-bit last-grant pointer
//               (reset to CSR, so ALU is searched first).
//   undefined : fixed priority BJP > CSR > MEM > ALU, no pointer state.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   <x>_valid_i / <x>_ready_o    request handshake per requester x
//   dp_req_<x>_o                 one-hot datapath select (EXEC only)
//   dp_res_i, dp_cmp_i           datapath result / compare flag, sampled in EXEC
//   flush_i                      abort any in-flight op; gates ready/dp_req
//   res_valid_o, res_o,          registered result towards writeback
//   res_cmp_o, res_src_o         (src: 0 ALU, 1 BJP, 2 MEM, 3 CSR)
//   res_ready_i                  writeback consumes the result
//   busy_o                       arbiter not idle

// Per-requester output gating: grant bit qualified by EXEC and not flushed.
module exu_dp_arb_lane (
  input  logic grant,
  input  logic exec,
  input  logic flush,
  output logic ready,
  output logic dp_req
);
  assign ready  = grant & exec & ~flush;
  assign dp_req = ready;
endmodule

module exu_dp_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid_i,
  input  logic          bjp_valid_i,
  input  logic          mem_valid_i,
  input  logic          csr_valid_i,
  output logic          alu_ready_o,
  output logic          bjp_ready_o,
  output logic          mem_ready_o,
  output logic          csr_ready_o,
  output logic          dp_req_alu_o,
  output logic          dp_req_bjp_o,
  output logic          dp_req_mem_o,
  output logic          dp_req_csr_o,
  input  logic [DW-1:0] dp_res_i,
  input  logic          dp_cmp_i,
  input  logic          flush_i,
  output logic          res_valid_o,
  output logic [DW-1:0] res_o,
  output logic          res_cmp_o,
  output logic [1:0]    res_src_o,
  input  logic          res_ready_i,
  output logic          busy_o
);

  localparam int NREQ = 4;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t state, state_nxt;

  // Requester index order: 0 ALU, 1 BJP, 2 MEM, 3 CSR.
  logic [NREQ-1:0] valid;
  logic [NREQ-1:0] grant, grant_nxt;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] lane_ready, lane_req;
  logic [1:0]      grant_idx;
  logic            load_res;
  logic            load_grant;

  assign valid = {csr_valid_i, mem_valid_i, bjp_valid_i, alu_valid_i};

  function automatic logic [1:0] enc4(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NREQ; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

  assign grant_idx = enc4(grant);

`ifdef EXU_DP_ARB_RR_EN
  logic [1:0] ptr;
  logic [1:0] pick_idx;

  // Search starts one past the last winner and wraps in index order.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && valid[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign pick_idx = enc4(pick);

  // Pointer moves whenever a grant is loaded, even if that grant is later flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ptr <= 2'd3;
    else if (load_grant) ptr <= pick_idx;
  end
`else
  // Fixed priority BJP > CSR > MEM > ALU.
  always_comb begin
    pick = '0;
    if      (valid[1]) pick[1] = 1'b1;
    else if (valid[3]) pick[3] = 1'b1;
    else if (valid[2]) pick[2] = 1'b1;
    else if (valid[0]) pick[0] = 1'b1;
  end
`endif

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    load_res   = 1'b0;
    load_grant = 1'b0;
    unique case (state)
      IDLE: begin
        if (|valid) begin
          grant_nxt  = pick;
          load_grant = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        load_res  = 1'b1;
        grant_nxt = '0;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (res_ready_i) begin
          if (|valid) begin
            grant_nxt  = pick;
            load_grant = 1'b1;
            state_nxt  = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
    // Flush overrides everything, including new requests and res_ready_i.
    if (flush_i) begin
      state_nxt  = IDLE;
      grant_nxt  = '0;
      load_res   = 1'b0;
      load_grant = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // Result fields only change on the EXEC->HOLD edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_o     <= '0;
      res_cmp_o <= 1'b0;
      res_src_o <= 2'd0;
    end else if (load_res) begin
      res_o     <= dp_res_i;
      res_cmp_o <= dp_cmp_i;
      res_src_o <= grant_idx;
    end
  end

  // A valid result exists exactly while holding it.
  assign res_valid_o = (state == HOLD);
  assign busy_o      = (state != IDLE);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    exu_dp_arb_lane u_lane (
      .grant  (grant[i]),
      .exec   (state == EXEC),
      .flush  (flush_i),
      .ready  (lane_ready[i]),
      .dp_req (lane_req[i])
    );
  end

  assign alu_ready_o  = lane_ready[0];
  assign bjp_ready_o  = lane_ready[1];
  assign mem_ready_o  = lane_ready[2];
  assign csr_ready_o  = lane_ready[3];
  assign dp_req_alu_o = lane_req[0];
  assign dp_req_bjp_o = lane_req[1];
  assign dp_req_mem_o = lane_req[2];
  assign dp_req_csr_o = lane_req[3];

endmodule
